pkt_slot_scheduler: RTL and testbench

Sequencer for the packet buffer memory controller. It allocates circular packet slots to the parser's write stream and records each completed packet's word length. It replays stored packets to the downstream consumer in arrival order by driving the controller's read enable, slot ID and word address. It sits between the parser, the memory controller and the egress stage, and provides full backpressure plus sticky error flags.

---
 rtl/pkt_sched_pkg.sv | 19 +
 rtl/pkt_sched_delay.sv | 38 +++
 rtl/pkt_slot_scheduler.sv | 150 +++++++++++++++
 tb/tb_pkt_slot_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : pkt_sched_pkg
// Brief  : Shared defaults and types for the packet slot scheduler.
// Rev    : 1.0
// ============================================================================
package pkt_sched_pkg;
  localparam int DEF_SLOT_W   = 4;
  localparam int DEF_LEN_W    = 5;
  localparam int DEF_READ_LAT = 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } sched_state_t;

  typedef logic [DEF_LEN_W-1:0] slot_len_t;
endpackage
`default_nettype wire

// File: rtl/pkt_sched_delay.sv
`default_nettype none
// ============================================================================
// Module : pkt_sched_delay
// Brief  : DEPTH-stage shift register aligning {valid, last} with read data.
// Rev    : 1.0
// ============================================================================
module pkt_sched_delay #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [2*DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {in_valid, in_last};
      end
    end else begin : g_multi
      always_ff @(posedge CLK or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {sr[2*DEPTH-3:0], in_valid, in_last};
      end
    end
  endgenerate

  assign out_valid = sr[2*DEPTH-1];
  assign out_last  = sr[2*DEPTH-2];

endmodule
`default_nettype wire

// File: rtl/pkt_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pkt_slot_scheduler
// Brief  : Circular slot allocator and in-order replay sequencer for the
//          packet buffer. Define PKT_SCHED_STATS_EN for push/pop counters.
// Rev    : 1.0
// ============================================================================
module pkt_slot_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_word,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [LEN_W-1:0]  wr_addr,
  input  logic              rd_ready,
  output logic              mem_ren,
  output logic [SLOT_W-1:0] mem_r_id,
  output logic [LEN_W-1:0]  mem_r_addr,
  output logic              mem_r_last,
  output logic              out_valid,
  output logic              out_last,
  output logic [SLOT_W:0]   slots_used,
  output logic              ovf_err,
`ifdef PKT_SCHED_STATS_EN
  output logic [15:0]       pkt_in_cnt,
  output logic [15:0]       pkt_out_cnt,
`endif
  output logic              trunc_err
);

  localparam int              NSLOT    = 1 << SLOT_W;
  localparam logic [LEN_W-1:0] ADDR_MAX = '1;
  localparam logic [0:0]      ST_IDLE  = 1'(S_IDLE);
  localparam logic [0:0]      ST_READ  = 1'(S_READ);

  logic              accept;
  logic              at_max;
  logic              push;
  logic              pop;
  logic [0:0]        state;
  logic [SLOT_W-1:0] head;
  logic [LEN_W-1:0]  rd_len;
  logic [LEN_W-1:0]  len_mem [NSLOT];

  // slots_used never exceeds 2^SLOT_W, so its MSB alone flags "full".
  assign wr_ready   = ~slots_used[SLOT_W];
  assign accept     = wr_word & wr_ready;
  assign at_max     = (wr_addr == ADDR_MAX);
  assign push       = accept & (wr_last | at_max);

  assign mem_ren    = (state == ST_READ) & rd_ready;
  assign mem_r_last = mem_ren & (mem_r_addr == rd_len);
  assign mem_r_id   = head;
  assign pop        = mem_r_last;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_slot   <= '0;
      wr_addr   <= '0;
      ovf_err   <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      if (push) begin
        wr_slot <= wr_slot + 1'b1;
        wr_addr <= '0;
      end else if (accept) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (wr_word & ~wr_ready)          ovf_err   <= 1'b1;
      if (accept & ~wr_last & at_max)   trunc_err <= 1'b1;
    end
  end

  // Length storage holds (words - 1); contents are only read once pushed.
  always_ff @(posedge CLK) begin
    if (push) len_mem[wr_slot] <= wr_addr;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slots_used <= '0;
    end else if (push & ~pop) begin
      slots_used <= slots_used + 1'b1;
    end else if (pop & ~push) begin
      slots_used <= slots_used - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      head       <= '0;
      rd_len     <= '0;
      mem_r_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (slots_used != '0) begin
            rd_len     <= len_mem[head];
            mem_r_addr <= '0;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_ren) begin
            if (mem_r_last) begin
              head  <= head + 1'b1;
              state <= ST_IDLE;
            end else begin
              mem_r_addr <= mem_r_addr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pkt_sched_delay #(
    .DEPTH (READ_LAT)
  ) u_delay (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (mem_ren),
    .in_last   (mem_r_last),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

`ifdef PKT_SCHED_STATS_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pkt_in_cnt  <= '0;
      pkt_out_cnt <= '0;
    end else begin
      if (push) pkt_in_cnt  <= pkt_in_cnt + 16'd1;
      if (pop)  pkt_out_cnt <= pkt_out_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_pkt_slot_scheduler
// Brief  : Directed self-checking bench for pkt_slot_scheduler.
// Rev    : 1.0
// ============================================================================
module tb_pkt_slot_scheduler;

  logic       CLK      = 1'b0;
  logic       reset    = 1'b1;
  logic       wr_word  = 1'b0;
  logic       wr_last  = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_slot;
  logic [4:0] wr_addr;
  logic       mem_ren;
  logic [3:0] mem_r_id;
  logic [4:0] mem_r_addr;
  logic       mem_r_last;
  logic       out_valid;
  logic       out_last;
  logic [4:0] slots_used;
  logic       ovf_err;
  logic       trunc_err;
`ifdef PKT_SCHED_STATS_EN
  logic [15:0] pkt_in_cnt;
  logic [15:0] pkt_out_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cnt;
  int bad;
  int last_addr;
  int pulses;

  pkt_slot_scheduler #(
    .SLOT_W   (4),
    .LEN_W    (5),
    .READ_LAT (2)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .wr_word     (wr_word),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .wr_slot     (wr_slot),
    .wr_addr     (wr_addr),
    .rd_ready    (rd_ready),
    .mem_ren     (mem_ren),
    .mem_r_id    (mem_r_id),
    .mem_r_addr  (mem_r_addr),
    .mem_r_last  (mem_r_last),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .slots_used  (slots_used),
    .ovf_err     (ovf_err),
`ifdef PKT_SCHED_STATS_EN
    .pkt_in_cnt  (pkt_in_cnt),
    .pkt_out_cnt (pkt_out_cnt),
`endif
    .trunc_err   (trunc_err)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wr_word  = 1'b0;
    wr_last  = 1'b0;
    rd_ready = 1'b0;
    reset    = 1'b1;
    cyc();
    reset    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_wr_slot",    32'(wr_slot), 0);
    check("rst_wr_addr",    32'(wr_addr), 0);
    check("rst_mem_r_id",   32'(mem_r_id), 0);
    check("rst_mem_r_addr", 32'(mem_r_addr), 0);
    check("rst_slots_used", 32'(slots_used), 0);
    check("rst_mem_ren",    32'(mem_ren), 0);
    check("rst_mem_r_last", 32'(mem_r_last), 0);
    check("rst_out_valid",  32'(out_valid), 0);
    check("rst_out_last",   32'(out_last), 0);
    check("rst_ovf_err",    32'(ovf_err), 0);
    check("rst_trunc_err",  32'(trunc_err), 0);
    check("rst_wr_ready",   32'(wr_ready), 1);

    // Three-word packet into slot 0, then replay
    reset    = 1'b0;
    rd_ready = 1'b1;
    wr_word  = 1'b1;
    cyc();
    check("p3_addr1", 32'(wr_addr), 1);
    cyc();
    wr_last = 1'b1;
    check("p3_addr2", 32'(wr_addr), 2);
    check("p3_slot0", 32'(wr_slot), 0);
    cyc();
    wr_word = 1'b0;
    wr_last = 1'b0;
    check("p3_used",      32'(slots_used), 1);
    check("p3_idle_ren",  32'(mem_ren), 0);
    check("p3_next_slot", 32'(wr_slot), 1);
    check("p3_addr_rst",  32'(wr_addr), 0);
    cyc();
    check("p3_rd0_ren",  32'(mem_ren), 1);
    check("p3_rd0_id",   32'(mem_r_id), 0);
    check("p3_rd0_addr", 32'(mem_r_addr), 0);
    check("p3_rd0_last", 32'(mem_r_last), 0);
    check("p3_rd0_ov",   32'(out_valid), 0);
    cyc();
    check("p3_rd1_addr", 32'(mem_r_addr), 1);
    check("p3_rd1_last", 32'(mem_r_last), 0);
    check("p3_rd1_ov",   32'(out_valid), 0);
    cyc();
    check("p3_rd2_ren",  32'(mem_ren), 1);
    check("p3_rd2_addr", 32'(mem_r_addr), 2);
    check("p3_rd2_last", 32'(mem_r_last), 1);
    check("p3_ov0",      32'(out_valid), 1);
    check("p3_ol0",      32'(out_last), 0);
    check("p3_used_rd",  32'(slots_used), 1);
    cyc();
    check("p3_pop_ren",  32'(mem_ren), 0);
    check("p3_pop_used", 32'(slots_used), 0);
    check("p3_pop_head", 32'(mem_r_id), 1);
    check("p3_ov1",      32'(out_valid), 1);
    check("p3_ol1",      32'(out_last), 0);
    cyc();
    check("p3_ov2", 32'(out_valid), 1);
    check("p3_ol2", 32'(out_last), 1);
    cyc();
    check("p3_ov_end", 32'(out_valid), 0);

    // Fill all 16 slots with one-word packets, then overflow
    do_reset();
    wr_word = 1'b1;
    wr_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_ready", 32'(wr_ready), 1);
      cyc();
    end
    check("full_ready", 32'(wr_ready), 0);
    check("full_used",  32'(slots_used), 16);
    check("full_slot",  32'(wr_slot), 0);
    check("full_ovf0",  32'(ovf_err), 0);
    cyc();
    wr_word = 1'b0;
    wr_last = 1'b0;
    check("ovf_set",  32'(ovf_err), 1);
    check("ovf_slot", 32'(wr_slot), 0);
    check("ovf_used", 32'(slots_used), 16);
    check("ovf_addr", 32'(wr_addr), 0);

    // Pop from full, then reuse the freed slot
    rd_ready = 1'b1;
    #1;
    check("pop_ren",   32'(mem_ren), 1);
    check("pop_last",  32'(mem_r_last), 1);
    check("pop_id",    32'(mem_r_id), 0);
    check("pop_ready", 32'(wr_ready), 0);
    cyc();
    rd_ready = 1'b0;
    wr_word  = 1'b1;
    wr_last  = 1'b1;
    #1;
    check("reuse_ready", 32'(wr_ready), 1);
    check("reuse_used",  32'(slots_used), 15);
    check("reuse_slot",  32'(wr_slot), 0);
    cyc();
    wr_word = 1'b0;
    wr_last = 1'b0;
    check("refull_used",  32'(slots_used), 16);
    check("refull_slot",  32'(wr_slot), 1);
    check("refull_head",  32'(mem_r_id), 1);
    check("refull_ready", 32'(wr_ready), 0);
    check("ovf_sticky",   32'(ovf_err), 1);

    // 33 words without wr_last: forced push at 32 words
    do_reset();
    wr_word = 1'b1;
    repeat (31) cyc();
    check("tr_addr31", 32'(wr_addr), 31);
    check("tr_slot0",  32'(wr_slot), 0);
    check("tr_clear",  32'(trunc_err), 0);
    cyc();
    check("tr_slot1", 32'(wr_slot), 1);
    check("tr_addr0", 32'(wr_addr), 0);
    check("tr_set",   32'(trunc_err), 1);
    check("tr_used",  32'(slots_used), 1);
    cyc();
    wr_word = 1'b0;
    check("tr_33rd_addr", 32'(wr_addr), 1);
    check("tr_33rd_slot", 32'(wr_slot), 1);
    rd_ready  = 1'b1;
    cnt       = 0;
    bad       = 0;
    last_addr = -1;
    #1;
    for (int i = 0; i < 40 && last_addr < 0; i++) begin
      if (mem_ren) begin
        if (32'(mem_r_id) != 0 || 32'(mem_r_addr) != cnt) bad++;
        cnt++;
        if (mem_r_last) last_addr = 32'(mem_r_addr);
      end
      cyc();
    end
    check("tr_rd_count", cnt, 32);
    check("tr_rd_last",  last_addr, 31);
    check("tr_rd_seq",   bad, 0);
    check("tr_rd_used",  32'(slots_used), 0);

    // Four-word packet read with rd_ready 1,0,1
    do_reset();
    rd_ready = 1'b1;
    wr_word  = 1'b1;
    repeat (3) cyc();
    wr_last = 1'b1;
    cyc();
    wr_word = 1'b0;
    wr_last = 1'b0;
    check("st_idle_ren", 32'(mem_ren), 0);
    cyc();
    check("st_a0_ren",  32'(mem_ren), 1);
    check("st_a0_addr", 32'(mem_r_addr), 0);
    cyc();
    check("st_a1_ren",  32'(mem_ren), 1);
    check("st_a1_addr", 32'(mem_r_addr), 1);
    rd_ready = 1'b0;
    #1;
    check("st_stall_ren", 32'(mem_ren), 0);
    cyc();
    check("st_hold_addr", 32'(mem_r_addr), 1);
    check("st_hold_ren",  32'(mem_ren), 0);
    rd_ready = 1'b1;
    #1;
    check("st_resume_ren",  32'(mem_ren), 1);
    check("st_resume_addr", 32'(mem_r_addr), 1);
    check("st_resume_last", 32'(mem_r_last), 0);
    cyc();
    check("st_a2_addr", 32'(mem_r_addr), 2);
    check("st_a2_last", 32'(mem_r_last), 0);
    cyc();
    check("st_a3_addr", 32'(mem_r_addr), 3);
    check("st_a3_last", 32'(mem_r_last), 1);
    cyc();
    check("st_done_ren",  32'(mem_ren), 0);
    check("st_done_used", 32'(slots_used), 0);

    // Asynchronous reset in the middle of a read
    do_reset();
    rd_ready = 1'b1;
    wr_word  = 1'b1;
    repeat (3) cyc();
    wr_last = 1'b1;
    cyc();
    wr_word = 1'b0;
    wr_last = 1'b0;
    repeat (3) cyc();
    check("mr_pre_ren", 32'(mem_ren), 1);
    check("mr_pre_ov",  32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("mr_ren",   32'(mem_ren), 0);
    check("mr_addr",  32'(mem_r_addr), 0);
    check("mr_used",  32'(slots_used), 0);
    check("mr_ov",    32'(out_valid), 0);
    check("mr_ready", 32'(wr_ready), 1);
    check("mr_slot",  32'(wr_slot), 0);
    cyc();
    reset  = 1'b0;
    pulses = 0;
    repeat (8) begin
      if (out_valid || mem_ren) pulses++;
      cyc();
    end
    check("mr_no_pulse", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
